spi_frame_sequencer: RTL

Frame-level controller for the SPI byte engine. Walks a fixed DATA_LENGTH-byte message ROM, hands bytes to the engine over a valid/ready handshake, and frames each message with cs_n setup and hold intervals. It also enforces a WAIT_TICKS inter-frame gap and captures MISO bytes. It sits between the system-level start/VIO controls and the bit-level SPI engine, and is the engine's only requester.

---
 rtl/spi_frame_sequencer_if.sv | 33 +++
 rtl/spi_frame_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_sequencer_if
//  Description : Byte-level handshake between the frame sequencer and the
//                bit-level SPI engine (TX valid/ready, RX completion strobe).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_frame_sequencer_if;
    logic       eng_tx_valid;
    logic [7:0] eng_tx_data;
    logic       eng_tx_ready;
    logic       eng_rx_valid;
    logic [7:0] eng_rx_data;

    // Sequencer side: offers bytes, receives completions.
    modport master (
        output eng_tx_valid,
        output eng_tx_data,
        input  eng_tx_ready,
        input  eng_rx_valid,
        input  eng_rx_data
    );

    // Engine side.
    modport slave (
        input  eng_tx_valid,
        input  eng_tx_data,
        output eng_tx_ready,
        output eng_rx_valid,
        output eng_rx_data
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_sequencer
//  Description : Frame-level SPI controller. Walks a fixed message ROM,
//                hands bytes to the SPI engine, frames each message with
//                cs_n setup/hold intervals, enforces an inter-frame gap,
//                captures MISO bytes and guards against a stalled engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_sequencer #(
    parameter int WAIT_TICKS     = 19200,
    parameter int DATA_LENGTH    = 14,
    parameter int CS_SETUP_TICKS = 4,
    parameter int CS_HOLD_TICKS  = 4,
    parameter int RX_TIMEOUT     = 256
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic               auto_repeat,
    input  wire logic               abort,
    input  wire logic               clear_err,
    spi_frame_sequencer_if.master   eng,
    output logic                    cs_n,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    output logic [3:0]              byte_idx,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt,
    output logic                    busy,
    output logic                    err
);

    // One shared dwell/timeout counter, wide enough for the largest interval.
    localparam int c_MAX_A    = (WAIT_TICKS > RX_TIMEOUT) ? WAIT_TICKS : RX_TIMEOUT;
    localparam int c_MAX_B    = (CS_SETUP_TICKS > CS_HOLD_TICKS) ? CS_SETUP_TICKS : CS_HOLD_TICKS;
    localparam int c_TICK_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W    = (c_TICK_MAX < 1) ? 1 : $clog2(c_TICK_MAX + 1);

    // Terminal counts. A zero tick parameter still dwells one cycle.
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST =
        c_CNT_W'((CS_SETUP_TICKS > 0) ? CS_SETUP_TICKS - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  =
        c_CNT_W'((CS_HOLD_TICKS > 0) ? CS_HOLD_TICKS - 1 : 0);
    // The gap exit cycle itself is spent with cs_n high, so cs_n stays high
    // for WAIT_TICKS+1 cycles between back-to-back frames.
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(WAIT_TICKS);
    // The error is taken on the edge where the counter would reach
    // RX_TIMEOUT-1, so err rises RX_TIMEOUT cycles after the accepting cycle.
    localparam logic [c_CNT_W-1:0] c_TMO_LAST   =
        c_CNT_W'((RX_TIMEOUT > 1) ? RX_TIMEOUT - 2 : 0);
    localparam logic [3:0]         c_LAST_IDX   = 4'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_RX = 3'd3,
        S_HOLD    = 3'd4,
        S_GAP     = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_tick;
    logic                 r_cs_n;
    logic                 r_tx_valid;
    logic [7:0]           r_tx_data;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic [3:0]           r_byte_idx;
    logic                 r_frame_done;
    logic [15:0]          r_frame_cnt;

    // Message ROM: "Hello World!\n" followed by zero padding.
    function automatic logic [7:0] rom_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_byte = 8'h48;
            4'd1:    rom_byte = 8'h65;
            4'd2:    rom_byte = 8'h6C;
            4'd3:    rom_byte = 8'h6C;
            4'd4:    rom_byte = 8'h6F;
            4'd5:    rom_byte = 8'h20;
            4'd6:    rom_byte = 8'h57;
            4'd7:    rom_byte = 8'h6F;
            4'd8:    rom_byte = 8'h72;
            4'd9:    rom_byte = 8'h6C;
            4'd10:   rom_byte = 8'h64;
            4'd11:   rom_byte = 8'h21;
            4'd12:   rom_byte = 8'h0A;
            default: rom_byte = 8'h00;
        endcase
    endfunction

    // Frame sequencing FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_cs_n       <= 1'b1;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_byte_idx   <= 4'd0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            if (abort) begin
                // Abort overrides every transition, including ERROR recovery.
                r_state    <= S_IDLE;
                r_cs_n     <= 1'b1;
                r_tx_valid <= 1'b0;
                r_tick     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state    <= S_SETUP;
                            r_cs_n     <= 1'b0;
                            r_byte_idx <= 4'd0;
                            r_tick     <= '0;
                        end
                    end
                    S_SETUP: begin
                        if (r_tick == c_SETUP_LAST) begin
                            r_state    <= S_SEND;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= rom_byte(r_byte_idx);
                            r_tick     <= '0;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_SEND: begin
                        // Byte and valid stay frozen until the engine takes it.
                        if (r_tx_valid && eng.eng_tx_ready) begin
                            r_state    <= S_WAIT_RX;
                            r_tx_valid <= 1'b0;
                            r_tick     <= '0;
                        end
                    end
                    S_WAIT_RX: begin
                        // A completion on the timeout cycle wins over the error.
                        if (eng.eng_rx_valid) begin
                            r_rx_data  <= eng.eng_rx_data;
                            r_rx_valid <= 1'b1;
                            r_tick     <= '0;
                            if (r_byte_idx == c_LAST_IDX) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_state    <= S_SEND;
                                r_byte_idx <= r_byte_idx + 4'd1;
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= rom_byte(r_byte_idx + 4'd1);
                            end
                        end else if (r_tick == c_TMO_LAST) begin
                            r_state <= S_ERROR;
                            r_cs_n  <= 1'b1;
                            r_tick  <= '0;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (r_tick == c_HOLD_LAST) begin
                            r_state      <= S_GAP;
                            r_cs_n       <= 1'b1;
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 16'd1;
                            r_tick       <= '0;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_GAP: begin
                        // start is deliberately not looked at here.
                        if (r_tick == c_GAP_LAST) begin
                            r_tick <= '0;
                            if (auto_repeat) begin
                                r_state    <= S_SETUP;
                                r_cs_n     <= 1'b0;
                                r_byte_idx <= 4'd0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                    S_ERROR: begin
                        if (clear_err) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_cs_n     <= 1'b1;
                        r_tx_valid <= 1'b0;
                        r_tick     <= '0;
                    end
                endcase
            end
        end
    end

    assign cs_n             = r_cs_n;
    assign eng.eng_tx_valid = r_tx_valid;
    assign eng.eng_tx_data  = r_tx_data;
    assign rx_data          = r_rx_data;
    assign rx_valid         = r_rx_valid;
    assign byte_idx         = r_byte_idx;
    assign frame_done       = r_frame_done;
    assign frame_cnt        = r_frame_cnt;
    // Status flags decoded directly from the state register.
    assign busy             = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign err              = (r_state == S_ERROR);

endmodule
`default_nettype wire
